// File: rtl/seq_adder_if.sv
// seq_adder_if: start/busy/done handshake, operands and result of seq_adder.
// The sub signal exists only when SEQ_ADDER_SUB_EN is defined.
interface seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SEQ_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             ovf;

`ifdef SEQ_ADDER_SUB_EN
    modport master (output start, A, B, Cin, sub, input busy, done, Sum, Cout, ovf);
    modport slave  (input start, A, B, Cin, sub, output busy, done, Sum, Cout, ovf);
`else
    modport master (output start, A, B, Cin, input busy, done, Sum, Cout, ovf);
    modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout, ovf);
`endif
endinterface

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle ripple adder, one CHUNK-bit slice per clock with the
// inter-slice carry held in a register. IDLE -> RUN (STEPS cycles) -> DONE.
// Optional subtract mode is enabled by defining SEQ_ADDER_SUB_EN.
// WIDTH must be an integer multiple of CHUNK.
module seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_adder_if.slave   bus
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sl_sum;
    logic [WIDTH-1:0] sl_wide, sl_mask;
    logic             msb_cin, last;
    int               idx;

    // Subtract is A + ~B + ~Cin, so inversion is applied once at acceptance.
`ifdef SEQ_ADDER_SUB_EN
    assign b_in   = bus.sub ? ~bus.B : bus.B;
    assign cin_in = bus.sub ^ bus.Cin;
`else
    assign b_in   = bus.B;
    assign cin_in = bus.Cin;
`endif

    // Slice k adder and the carry into the operand MSB (meaningful on the last slice).
    always_comb begin
        idx     = CHUNK * int'(k_q);
        a_sl    = CHUNK'(a_q >> idx);
        b_sl    = CHUNK'(b_q >> idx);
        sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        msb_cin = sl_sum[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
        last    = (k_q == KW'(STEPS - 1));
        sl_wide = '0;
        sl_wide[CHUNK-1:0] = sl_sum[CHUNK-1:0];
        sl_mask = '0;
        sl_mask[CHUNK-1:0] = '1;
    end

    // Next-state and datapath updates; outputs are only written on RUN->DONE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = b_in;
                    carry_d = cin_in;
                    k_d     = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = (acc_q & ~(sl_mask << idx)) | (sl_wide << idx);
                carry_d = sl_sum[CHUNK];
                k_d     = k_q + KW'(1);
                if (last) begin
                    sum_d   = acc_d;
                    cout_d  = sl_sum[CHUNK];
                    ovf_d   = msb_cin ^ sl_sum[CHUNK];
                    k_d     = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset wins over start and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: randomized and directed checks of seq_adder (16/4 and 4/1)
// against an arithmetic reference model.
module tb_seq_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_adder_if #(.WIDTH(16)) if16 ();
    seq_adder_if #(.WIDTH(4))  if4 ();

    seq_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
    seq_adder #(.WIDTH(4),  .CHUNK(1)) u4  (.clk(clk), .rst(rst), .bus(if4.slave));

    int vecs = 0;
    int errs = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {Cout,Sum} = A+B+Cin or A-B-Cin (Cout = no borrow); ovf from signed range.
    function automatic void model16(input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sb,
                                    output logic [15:0] s, output logic co, output logic ov);
        int r, rs, sa, sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        if (sb) begin
            r  = int'(a) - int'(b) - int'(cin);
            rs = sa - sbv - int'(cin);
            co = (r >= 0);
        end else begin
            r  = int'(a) + int'(b) + int'(cin);
            rs = sa + sbv + int'(cin);
            co = (r > 65535);
        end
        s  = r[15:0];
        ov = (rs > 32767) || (rs < -32768);
    endfunction

    // Starts one operation on the 16-bit instance; lat = cycles from accept edge to done.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic co, output logic ov,
                         output int lat, output int bcnt);
        if16.A = a; if16.B = b; if16.Cin = cin; if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        lat = 0;
        bcnt = if16.busy ? 1 : 0;
        while (!if16.done && lat < 20) begin
            step();
            lat++;
            if (if16.busy) bcnt++;
        end
        if (!if16.done) lat = -1;
        s = if16.Sum; co = if16.Cout; ov = if16.ovf;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output logic [4:0] r, output int lat);
        if4.A = a; if4.B = b; if4.Cin = cin; if4.start = 1'b1;
        step();
        if4.start = 1'b0;
        lat = 0;
        while (!if4.done && lat < 20) begin
            step();
            lat++;
        end
        if (!if4.done) lat = -1;
        r = {if4.Cout, if4.Sum};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        vecs++;
        if ({if16.busy, if16.done, if16.Cout, if16.ovf, if16.Sum} !== 20'h0) begin
            errs++;
            $display("FAIL reset16 got busy=%b done=%b Cout=%b ovf=%b Sum=%h want all 0",
                     if16.busy, if16.done, if16.Cout, if16.ovf, if16.Sum);
        end
        vecs++;
        if ({if4.busy, if4.done, if4.Cout, if4.ovf, if4.Sum} !== 8'h0) begin
            errs++;
            $display("FAIL reset4 got busy=%b done=%b Sum=%h want all 0", if4.busy, if4.done, if4.Sum);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [15:0] s; logic co, ov; int lat, bc;
        run16(16'hFFFF, 16'h0001, 1'b0, s, co, ov, lat, bc);
        vecs++;
        if ({co, ov, s} !== {1'b1, 1'b0, 16'h0000}) begin
            errs++;
            $display("FAIL ripple got Cout=%b ovf=%b Sum=%h want 1 0 0000", co, ov, s);
        end
        vecs++;
        if (lat !== 4 || bc !== 4) begin
            errs++;
            $display("FAIL ripple_timing got lat=%0d busy=%0d want 4 4", lat, bc);
        end
        run16(16'h7FFF, 16'h0001, 1'b1, s, co, ov, lat, bc);
        vecs++;
        if ({co, ov, s} !== {1'b0, 1'b1, 16'h8001}) begin
            errs++;
            $display("FAIL sovf got Cout=%b ovf=%b Sum=%h want 0 1 8001", co, ov, s);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, s, es; logic cin, sb, co, ov, eco, eov; int lat, bc;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i % 8 == 0) a = 16'hFFFF;
            if (i % 8 == 1) b = 16'h8000;
            cin = 1'($urandom_range(0, 1));
            sb  = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
            sb = 1'($urandom_range(0, 1));
            if16.sub = sb;
`endif
            model16(a, b, cin, sb, es, eco, eov);
            run16(a, b, cin, s, co, ov, lat, bc);
            vecs++;
            if ({co, ov, s} !== {eco, eov, es} || lat !== 4 || bc !== 4) begin
                errs++;
                $display("FAIL rand%0d A=%h B=%h Cin=%b sub=%b got %b %b %h lat=%0d busy=%0d want %b %b %h lat=4 busy=4",
                         i, a, b, cin, sb, co, ov, s, lat, bc, eco, eov, es);
            end
        end
`ifdef SEQ_ADDER_SUB_EN
        if16.sub = 1'b0;
`endif
    endtask

    task automatic test_exhaustive4();
        logic [4:0] r; int lat, exp_r;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    exp_r = a + b + c;
                    run4(4'(a), 4'(b), 1'(c), r, lat);
                    vecs++;
                    if (r !== 5'(exp_r) || lat !== 4) begin
                        errs++;
                        $display("FAIL exh4 A=%0d B=%0d Cin=%0d got %0d lat=%0d want %0d lat=4",
                                 a, b, c, r, lat, exp_r);
                    end
                end
    endtask

    task automatic test_start_during_run();
        int lat;
        if16.A = 16'h1357; if16.B = 16'h2468; if16.Cin = 1'b1; if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        step(); lat = 1;
        if16.A = 16'hAAAA; if16.B = 16'hAAAA; if16.Cin = 1'b0; if16.start = 1'b1;
        step(); lat++;
        if16.start = 1'b0;
        while (!if16.done && lat < 20) begin step(); lat++; end
        vecs++;
        if ({if16.Cout, if16.Sum} !== {1'b0, 16'h37C0} || lat !== 4) begin
            errs++;
            $display("FAIL start_in_run got Cout=%b Sum=%h lat=%0d want 0 37c0 lat=4",
                     if16.Cout, if16.Sum, lat);
        end
        step(); step();
        vecs++;
        if (if16.done !== 1'b0 || if16.busy !== 1'b0) begin
            errs++;
            $display("FAIL start_in_run_queued got done=%b busy=%b want 0 0", if16.done, if16.busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        if16.A = 16'h0F0F; if16.B = 16'h00F1; if16.Cin = 1'b0; if16.start = 1'b1;
        step();
        if16.A = 16'hC000; if16.B = 16'h4000; if16.Cin = 1'b1;
        lat = 0;
        while (!if16.done && lat < 20) begin step(); lat++; end
        vecs++;
        if (if16.Sum !== 16'h1000 || lat !== 4) begin
            errs++;
            $display("FAIL b2b_first got Sum=%h lat=%0d want 1000 lat=4", if16.Sum, lat);
        end
        step();
        if16.start = 1'b0;
        gap = 1;
        while (!if16.done && gap < 20) begin step(); gap++; end
        vecs++;
        if ({if16.Cout, if16.Sum} !== {1'b1, 16'h0001} || gap !== 5) begin
            errs++;
            $display("FAIL b2b_second got Cout=%b Sum=%h gap=%0d want 1 0001 gap=5",
                     if16.Cout, if16.Sum, gap);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] s; logic co, ov; int lat, bc, dones;
        run16(16'h00FF, 16'h0001, 1'b0, s, co, ov, lat, bc);
        if16.A = 16'hAAAA; if16.B = 16'h5555; if16.Cin = 1'b1; if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        vecs++;
        if ({if16.busy, if16.done, if16.Cout, if16.ovf, if16.Sum} !== 20'h0) begin
            errs++;
            $display("FAIL rst_midrun got busy=%b done=%b Cout=%b ovf=%b Sum=%h want all 0",
                     if16.busy, if16.done, if16.Cout, if16.ovf, if16.Sum);
        end
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin step(); if (if16.done) dones++; end
        vecs++;
        if (dones !== 0) begin
            errs++;
            $display("FAIL rst_no_done got %0d done pulses want 0", dones);
        end
        run16(16'h1234, 16'h1111, 1'b0, s, co, ov, lat, bc);
        vecs++;
        if ({co, s} !== {1'b0, 16'h2345} || lat !== 4) begin
            errs++;
            $display("FAIL rst_recover got Cout=%b Sum=%h lat=%0d want 0 2345 lat=4", co, s, lat);
        end
    endtask

`ifdef SEQ_ADDER_SUB_EN
    task automatic test_sub();
        logic [15:0] s; logic co, ov; int lat, bc;
        if16.sub = 1'b1;
        run16(16'h0005, 16'h0007, 1'b0, s, co, ov, lat, bc);
        vecs++;
        if ({co, s} !== {1'b0, 16'hFFFE}) begin
            errs++;
            $display("FAIL sub_borrow got Cout=%b Sum=%h want 0 fffe", co, s);
        end
        run16(16'h8000, 16'h0001, 1'b0, s, co, ov, lat, bc);
        vecs++;
        if ({ov, s} !== {1'b1, 16'h7FFF}) begin
            errs++;
            $display("FAIL sub_ovf got ovf=%b Sum=%h want 1 7fff", ov, s);
        end
        if16.sub = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        if16.start = 1'b0; if16.A = '0; if16.B = '0; if16.Cin = 1'b0;
        if4.start  = 1'b0; if4.A  = '0; if4.B  = '0; if4.Cin  = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
        if16.sub = 1'b0;
        if4.sub  = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_exhaustive4();
        test_start_during_run();
        test_back_to_back();
        test_reset_midrun();
`ifdef SEQ_ADDER_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
